// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: the memory-wait
//   sequencer state encoding, the execute-stage forwarding select codes and
//   the hard-wired zero register specifier.
package pipe_ctrl_pkg;

    // Memory-wait sequencer states. FAULT is terminal until reset.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Operand select codes for the execute-stage ALU inputs.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // R0 always reads as zero, so it never creates a hazard or a forward.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter used for pipeline performance debug.
//   Ports:
//     clk    clock
//     rst    asynchronous active-high reset, clears the count
//     inc    increment request for this clock edge
//     count  current count, sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// pipe_hazard_sequencer
//   Central stall/flush/forward controller for the 5-stage 16-bit pipeline.
//   Ports:
//     clk, rst                     clock and asynchronous active-high reset
//     rs1_d, rs2_d, uses_rs*_d     decode-stage source registers and use flags
//     rs1_e, rs2_e, rd_e, load_e   execute-stage register specifiers, load flag
//     branch_taken_e               branch resolved taken in execute
//     rd_m, write_reg_m            memory-stage destination and write flag
//     mem_access_m, mem_ready      memory-stage access and completion
//     rd_w, write_reg_w            writeback-stage destination and write flag
//     stall_f/d/e/m                hold the corresponding pipeline register
//     flush_d, flush_e             turn the register into a bubble
//     bubble_w                     insert a bubble into the writeback register
//     fwd_a_e, fwd_b_e             execute operand select (see pipe_ctrl_pkg)
//     mem_fault                    sticky memory-timeout flag
//     stall_cycles, flush_events   saturating performance counters
module pipe_hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W   = 3,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic             uses_rs1_d,
    input  logic             uses_rs2_d,
    input  logic [REG_W-1:0] rs1_e,
    input  logic [REG_W-1:0] rs2_e,
    input  logic [REG_W-1:0] rd_e,
    input  logic             load_e,
    input  logic             branch_taken_e,
    input  logic [REG_W-1:0] rd_m,
    input  logic             write_reg_m,
    input  logic             mem_access_m,
    input  logic             mem_ready,
    input  logic [REG_W-1:0] rd_w,
    input  logic             write_reg_w,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             bubble_w,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [REG_W-1:0]  R_ZERO    = REG_W'(REG_ZERO);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;

    logic mem_stall;
    logic load_use;

    // Sequencer state, wait counter and the sticky fault flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_fault <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if ((state_nxt == FAULT) && (state != FAULT)) begin
                mem_fault <= 1'b1;
            end
        end
    end

    // Next-state logic. The wait counter only advances while staying in WAIT
    // and falls back to zero on every exit, so each wait is timed afresh.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        case (state)
            RUN: begin
                if (mem_access_m && !mem_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_nxt = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = FAULT;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Hazard detection terms.
    always_comb begin
        mem_stall = (mem_access_m && !mem_ready) || (state == FAULT);
        load_use  = load_e && (rd_e != R_ZERO) &&
                    ((uses_rs1_d && (rs1_d == rd_e)) ||
                     (uses_rs2_d && (rs2_d == rd_e)));
    end

    // Stall/flush priority: a memory stall freezes everything and defers the
    // branch until release; a taken branch beats load-use because the decode
    // instruction is on the wrong path and is being discarded anyway.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        bubble_w = 1'b0;
        if (mem_stall) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_m  = 1'b1;
            bubble_w = 1'b1;
        end else if (branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Operand forwarding; the memory stage holds the younger result and wins.
    always_comb begin
        fwd_a_e = FWD_RF;
        fwd_b_e = FWD_RF;
        if (write_reg_m && (rd_m != R_ZERO) && (rd_m == rs1_e)) begin
            fwd_a_e = FWD_MEM;
        end else if (write_reg_w && (rd_w != R_ZERO) && (rd_w == rs1_e)) begin
            fwd_a_e = FWD_WB;
        end
        if (write_reg_m && (rd_m != R_ZERO) && (rd_m == rs2_e)) begin
            fwd_b_e = FWD_MEM;
        end else if (write_reg_w && (rd_w != R_ZERO) && (rd_w == rs2_e)) begin
            fwd_b_e = FWD_WB;
        end
    end

    // flush_d is raised only by an applied branch flush.
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_f),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_d),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// tb_pipe_hazard_sequencer
//   Directed scoreboard bench for pipe_hazard_sequencer (CNT_W=4, TIMEOUT=4).
//   Each vector pushes its hand-computed expectation; a monitor pops one entry
//   per cycle on the falling edge and compares it with the DUT outputs.
module tb_pipe_hazard_sequencer;

    localparam int REG_W   = 3;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;

    // Control bundle order: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_MEM  = 7'b1111001;

    typedef struct packed {
        logic [6:0]       ctl;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             fault;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fe;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic             uses_rs1_d, uses_rs2_d, load_e, branch_taken_e;
    logic             write_reg_m, mem_access_m, mem_ready, write_reg_w;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, bubble_w;
    logic [1:0]       fwd_a_e, fwd_b_e;
    logic             mem_fault;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    pipe_hazard_sequencer #(
        .REG_W   (REG_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rs1_d          (rs1_d),
        .rs2_d          (rs2_d),
        .uses_rs1_d     (uses_rs1_d),
        .uses_rs2_d     (uses_rs2_d),
        .rs1_e          (rs1_e),
        .rs2_e          (rs2_e),
        .rd_e           (rd_e),
        .load_e         (load_e),
        .branch_taken_e (branch_taken_e),
        .rd_m           (rd_m),
        .write_reg_m    (write_reg_m),
        .mem_access_m   (mem_access_m),
        .mem_ready      (mem_ready),
        .rd_w           (rd_w),
        .write_reg_w    (write_reg_w),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .stall_m        (stall_m),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .bubble_w       (bubble_w),
        .fwd_a_e        (fwd_a_e),
        .fwd_b_e        (fwd_b_e),
        .mem_fault      (mem_fault),
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [6:0] ctl, input logic [1:0] fa,
                                input logic [1:0] fb, input logic fault,
                                input int sc, input int fe);
        exp_t e;
        e.ctl   = ctl;
        e.fa    = fa;
        e.fb    = fb;
        e.fault = fault;
        e.sc    = CNT_W'(sc);
        e.fe    = CNT_W'(fe);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic clearInputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
        rd_e = '0; rd_m = '0; rd_w = '0;
        uses_rs1_d = 1'b0; uses_rs2_d = 1'b0; load_e = 1'b0;
        branch_taken_e = 1'b0; write_reg_m = 1'b0; write_reg_w = 1'b0;
        mem_access_m = 1'b0; mem_ready = 1'b0;
    endtask

    // Queue the expectation for the inputs just driven, then move one cycle on.
    task automatic applyStimulus(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one comparison set per cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("ctl", 16'({stall_f, stall_d, stall_e, stall_m,
                                        flush_d, flush_e, bubble_w}), 16'(e.ctl));
                checkOutput("fwd_a_e", 16'(fwd_a_e), 16'(e.fa));
                checkOutput("fwd_b_e", 16'(fwd_b_e), 16'(e.fb));
                checkOutput("mem_fault", 16'(mem_fault), 16'(e.fault));
                checkOutput("stall_cycles", 16'(stall_cycles), 16'(e.sc));
                checkOutput("flush_events", 16'(flush_events), 16'(e.fe));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        applyStimulus(mk(C_NONE, 2'b00, 2'b00, 0, 0, 0));

        // Load-use via rs1, then rd_e=R0, then via rs2 only
        load_e = 1; rd_e = 3; rs1_d = 3; uses_rs1_d = 1;
        applyStimulus(mk(C_LU, 2'b00, 2'b00, 0, 0, 0));
        clearInputs();
        applyStimulus(mk(C_NONE, 2'b00, 2'b00, 0, 1, 0));
        load_e = 1; rd_e = 0; rs1_d = 0; uses_rs1_d = 1;
        applyStimulus(mk(C_NONE, 2'b00, 2'b00, 0, 1, 0));
        load_e = 1; rd_e = 4; rs1_d = 4; uses_rs1_d = 0; rs2_d = 4; uses_rs2_d = 1;
        applyStimulus(mk(C_LU, 2'b00, 2'b00, 0, 1, 0));
        uses_rs2_d = 0;
        applyStimulus(mk(C_NONE, 2'b00, 2'b00, 0, 2, 0));

        // Forwarding
        clearInputs();
        write_reg_m = 1; write_reg_w = 1; rd_m = 2; rd_w = 2; rs1_e = 2; rs2_e = 5;
        applyStimulus(mk(C_NONE, 2'b10, 2'b00, 0, 2, 0));
        write_reg_m = 0;
        applyStimulus(mk(C_NONE, 2'b01, 2'b00, 0, 2, 0));
        write_reg_m = 1; rd_w = 5;
        applyStimulus(mk(C_NONE, 2'b10, 2'b01, 0, 2, 0));
        rd_m = 0; rd_w = 0; rs1_e = 0; rs2_e = 0;
        applyStimulus(mk(C_NONE, 2'b00, 2'b00, 0, 2, 0));
        write_reg_w = 0; rd_w = 5; rs2_e = 5;
        applyStimulus(mk(C_NONE, 2'b00, 2'b00, 0, 2, 0));

        // Branch overrides load-use
        clearInputs();
        load_e = 1; rd_e = 3; rs1_d = 3; uses_rs1_d = 1; branch_taken_e = 1;
        applyStimulus(mk(C_BR, 2'b00, 2'b00, 0, 2, 0));
        clearInputs();
        applyStimulus(mk(C_NONE, 2'b00, 2'b00, 0, 2, 1));

        // Three-cycle memory wait with a branch deferred to the release cycle
        mem_access_m = 1; mem_ready = 0; branch_taken_e = 1;
        applyStimulus(mk(C_MEM, 2'b00, 2'b00, 0, 2, 1));
        applyStimulus(mk(C_MEM, 2'b00, 2'b00, 0, 3, 1));
        applyStimulus(mk(C_MEM, 2'b00, 2'b00, 0, 4, 1));
        mem_ready = 1;
        applyStimulus(mk(C_BR, 2'b00, 2'b00, 0, 5, 1));
        clearInputs();
        applyStimulus(mk(C_NONE, 2'b00, 2'b00, 0, 5, 2));

        // Reset asserted mid-wait
        mem_access_m = 1; mem_ready = 0;
        applyStimulus(mk(C_MEM, 2'b00, 2'b00, 0, 5, 2));
        applyStimulus(mk(C_MEM, 2'b00, 2'b00, 0, 6, 2));
        clearInputs();
        rst = 1;
        applyStimulus(mk(C_NONE, 2'b00, 2'b00, 0, 0, 0));

        // Timeout: fault on the 4th edge after entering the wait
        rst = 0;
        mem_access_m = 1; mem_ready = 0;
        applyStimulus(mk(C_MEM, 2'b00, 2'b00, 0, 0, 0));
        applyStimulus(mk(C_MEM, 2'b00, 2'b00, 0, 1, 0));
        applyStimulus(mk(C_MEM, 2'b00, 2'b00, 0, 2, 0));
        applyStimulus(mk(C_MEM, 2'b00, 2'b00, 0, 3, 0));
        applyStimulus(mk(C_MEM, 2'b00, 2'b00, 0, 4, 0));
        mem_ready = 1;
        applyStimulus(mk(C_MEM, 2'b00, 2'b00, 1, 5, 0));
        clearInputs();
        applyStimulus(mk(C_MEM, 2'b00, 2'b00, 1, 6, 0));
        rst = 1;
        applyStimulus(mk(C_NONE, 2'b00, 2'b00, 0, 0, 0));
        rst = 0;
        applyStimulus(mk(C_NONE, 2'b00, 2'b00, 0, 0, 0));

        // Continuous load-use: stall counter saturates at 15
        load_e = 1; rd_e = 6; rs2_d = 6; uses_rs2_d = 1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(mk(C_LU, 2'b00, 2'b00, 0, (i < 15) ? i : 15, 0));
        end
        clearInputs();
        applyStimulus(mk(C_NONE, 2'b00, 2'b00, 0, 15, 0));

        repeat (2) @(posedge clk);
        checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_sequencer.md
Name: pipe_hazard_sequencer

Overview:
Central stall/flush/forward controller for the 5-stage 16-bit pipeline (Fetch, Decode, Execute, Memory, WriteBack).
- Each cycle it drives the stage stall/flush enables and the execute-stage operand forwarding selects.
- A small FSM sequences multi-cycle data-memory waits and detects memory timeouts.
- Saturating counters record stall cycles and branch flushes for performance debug.

Parameters:
REG_W, 3, register-specifier width (8 registers; R0 hard-wired zero)
CNT_W, 16, width of each performance counter
TIMEOUT, 16, maximum consecutive memory-wait cycles before fault (must be ≥2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rs1_d, rs2_d  in  REG_W  decode-stage source registers
uses_rs1_d, uses_rs2_d  in  1  decode instruction reads rs1/rs2
rs1_e, rs2_e  in  REG_W  execute-stage source registers
rd_e  in  REG_W  execute-stage destination
load_e  in  1  execute instruction is a load
branch_taken_e  in  1  branch resolved taken in execute
rd_m  in  REG_W  memory-stage destination
write_reg_m  in  1  memory-stage instruction writes a register
mem_access_m  in  1  memory stage holds a load/store
mem_ready  in  1  data memory completes the access this cycle
rd_w  in  REG_W  writeback-stage destination
write_reg_w  in  1  writeback-stage instruction writes a register
stall_f, stall_d, stall_e, stall_m  out  1  hold the pipeline register
flush_d, flush_e  out  1  clear the pipeline register to a bubble
bubble_w  out  1  insert a bubble into the writeback register
fwd_a_e, fwd_b_e  out  2  operand select: 00 = register file, 10 = memory-stage ALU result, 01 = writeback data
mem_fault  out  1  sticky memory-timeout flag
stall_cycles, flush_events  out  CNT_W  saturating counters

Behaviour:
- Reset (async): state=RUN, wait_cnt=0, mem_fault=0, both counters=0. With all inputs at 0, every output is 0.
- Stall, flush, bubble and forward outputs are combinational from the inputs and the registered state. Counters, the FSM and mem_fault are registered.
- FSM states:
  - RUN → WAIT when mem_access_m && !mem_ready.
  - WAIT → RUN when mem_ready.
  - WAIT → FAULT when !mem_ready && wait_cnt == TIMEOUT-1.
  - FAULT is exited only by rst.
  - wait_cnt increments each WAIT cycle and clears on leaving WAIT.
- mem_stall = (mem_access_m && !mem_ready) || state==FAULT.
- Priority 1, mem_stall:
  - stall_f = stall_d = stall_e = stall_m = 1; bubble_w = 1.
  - flush_d = flush_e = 0; branch_taken_e and load-use are ignored.
  - The branch is re-evaluated once the pipeline is released.
- Priority 2, branch_taken_e: flush_d = flush_e = 1; all stalls 0. This overrides a simultaneous load-use, because the decode instruction is wrong-path.
- Priority 3, load-use: stall_f = stall_d = 1, flush_e = 1.
  - Condition: load_e && rd_e≠0 && ((uses_rs1_d && rs1_d==rd_e) || (uses_rs2_d && rs2_d==rd_e)).
- Forwarding (each operand independently, always computed):
  - 10 if write_reg_m && rd_m≠0 && rd_m==rs_e.
  - Else 01 if write_reg_w && rd_w≠0 && rd_w==rs_e.
  - Else 00.
  - The memory stage wins over writeback.
- mem_fault: set on entering FAULT; held until rst.
- Counters:
  - stall_cycles +1 per clock edge where stall_f=1, from any cause.
  - flush_events +1 per edge where the branch flush is applied.
  - Both saturate at all-ones.
- Reset asserted mid-WAIT returns immediately to RUN with counters cleared. No stall persists after rst falls.

Decomposition:
- Package pipe_ctrl_pkg:
  - State enum {RUN, WAIT, FAULT}.
  - FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01.
  - REG_ZERO constant.
- Sub-module sat_counter (parameter CNT_W; ports clk, rst, inc, count), instantiated twice.

Test Plan:
1. load_e=1, rd_e=3, rs1_d=3, uses_rs1_d=1 for one cycle → stall_f=stall_d=flush_e=1 that cycle; stall_cycles 0→1. Same stimulus with rd_e=0 → no stall.
2. write_reg_m=write_reg_w=1, rd_m=rd_w=2, rs1_e=2, rs2_e=5 → fwd_a_e=10, fwd_b_e=00. Then write_reg_m=0 → fwd_a_e=01.
3. Load-use condition plus branch_taken_e=1 in the same cycle → flush_d=flush_e=1, stall_f=0; flush_events +1, stall_cycles unchanged.
4. mem_access_m=1, mem_ready=0 for 3 cycles, then 1 → stall_f/d/e/m=1 and bubble_w=1 for exactly 3 cycles; state RUN→WAIT→RUN; stall_cycles +3. A branch_taken_e held during the wait produces its flush only on the release cycle.
5. TIMEOUT=4, mem_ready held 0 → FAULT entered on the 4th edge after WAIT entry. mem_fault=1 and all stalls remain 1 when mem_ready later rises. Async rst clears everything without a clock edge.
6. CNT_W=4, continuous load-use for 20 cycles → stall_cycles saturates at 15 and does not wrap.
